// File: rtl/button_reader_pkg.sv
// ---------------------------------------------------------------------------
// button_reader_pkg
// Shared definitions for the pushbutton reader:
//   ch_state_t     - 2-bit per-channel debounce state encoding
//   NUM_BTN        - number of pushbutton channels
//   EVT_ID_W       - width of the event id (button index)
//   lowest_index() - index of the lowest set bit of a press vector
// ---------------------------------------------------------------------------
package button_reader_pkg;

  localparam int NUM_BTN  = 4;
  localparam int EVT_ID_W = 2;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } ch_state_t;

  // Lowest set bit wins; scanning from the top down lets the last hit stick.
  function automatic logic [EVT_ID_W-1:0] lowest_index(input logic [NUM_BTN-1:0] v);
    lowest_index = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_index = EVT_ID_W'(i);
      end
    end
  endfunction

endpackage

// File: rtl/button_reader_debounce_ch.sv
// ---------------------------------------------------------------------------
// debounce_ch
// One pushbutton channel: 2-flop synchronizer, four-state debounce FSM and
// a saturating-by-construction stability counter.
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   btn_in         raw asynchronous button level (1 = pressed)
//   level          debounced level
//   press_pulse    one-cycle pulse on an accepted 0->1 change
//   release_pulse  one-cycle pulse on an accepted 1->0 change
// DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits.
// ---------------------------------------------------------------------------
module debounce_ch
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  // Count value on which a pending change is accepted. The counter only
  // increments while below this value, so it can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_reg;
  logic             sync_reg;
  ch_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  // Synchronizer: nothing downstream sees btn_in before sync_reg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
    end else begin
      sync_meta_reg <= btn_in;
      sync_reg      <= sync_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= STABLE_LO;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      STABLE_LO: begin
        if (sync_reg) begin
          state_next = WAIT_HI;
          cnt_next   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_reg) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_reg) begin
          state_next = WAIT_LO;
          cnt_next   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_reg) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = STABLE_LO;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = STABLE_LO;
        cnt_next   = '0;
      end
    endcase
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

endmodule

// File: rtl/button_reader.sv
// ---------------------------------------------------------------------------
// button_reader
// Debounces four pushbuttons and queues press events in a one-deep event
// register with a sticky overflow flag for presses that could not be kept.
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   btn_in[3:0]    raw asynchronous button levels (1 = pressed)
//   btn_level      debounced levels
//   press_pulse    one-cycle pulse per accepted 0->1 change
//   release_pulse  one-cycle pulse per accepted 1->0 change
//   evt_valid      press event available
//   evt_id         index of the pressed button, valid with evt_valid
//   evt_ready      consumer handshake (accept when evt_valid & evt_ready)
//   evt_overflow   sticky: at least one press event was lost
// ---------------------------------------------------------------------------
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTN-1:0]  btn_in,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  press_pulse,
  output logic [NUM_BTN-1:0]  release_pulse,
  output logic                evt_valid,
  output logic [EVT_ID_W-1:0] evt_id,
  input  logic                evt_ready,
  output logic                evt_overflow
);

  logic [NUM_BTN-1:0] press_all;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in[gi]),
        .level        (btn_level[gi]),
        .press_pulse  (press_all[gi]),
        .release_pulse(release_pulse[gi])
      );
    end
  endgenerate

  assign press_pulse = press_all;

  logic                evt_valid_reg, evt_valid_next;
  logic [EVT_ID_W-1:0] evt_id_reg, evt_id_next;
  logic                ovf_reg, ovf_next;
  logic                multi_press;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_press = (press_all & (press_all - NUM_BTN'(1))) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      evt_valid_reg <= evt_valid_next;
      evt_id_reg    <= evt_id_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    evt_valid_next = evt_valid_reg;
    evt_id_next    = evt_id_reg;
    ovf_next       = ovf_reg;
    if (press_all != '0) begin
      if (!evt_valid_reg || evt_ready) begin
        // Slot is free (or being freed this cycle): take the lowest press.
        evt_valid_next = 1'b1;
        evt_id_next    = lowest_index(press_all);
        if (multi_press) begin
          ovf_next = 1'b1;
        end
      end else begin
        // Slot held by an unconsumed event: the new press is lost.
        ovf_next = 1'b1;
      end
    end else if (evt_valid_reg && evt_ready) begin
      evt_valid_next = 1'b0;
    end
  end

  assign evt_valid    = evt_valid_reg;
  assign evt_id       = evt_id_reg;
  assign evt_overflow = ovf_reg;

endmodule

// File: tb/tb_button_reader.sv
// ---------------------------------------------------------------------------
// tb_button_reader
// Directed table, hand-written corner sequences and a randomized run, all
// checked every cycle against a behavioural model: a button's level flips
// once the synchronized input has disagreed with it for DC+1 consecutive
// samples, and presses feed a one-deep event slot.
// ---------------------------------------------------------------------------
module tb_button_reader;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, press_pulse, release_pulse;
  logic       evt_valid, evt_ready, evt_overflow;
  logic [1:0] evt_id;

  button_reader #(.DEBOUNCE_CYCLES(DC), .CNT_W(25)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  logic [3:0] samp[$];     // btn_in as sampled on each edge, oldest first
  logic [3:0] m_level, m_press, m_release;
  logic       m_valid, m_ovf;
  logic [1:0] m_id;

  task automatic model_reset();
    samp.delete();
    for (int j = 0; j < DC + 3; j++) samp.push_back(4'b0000);
    m_level = '0; m_press = '0; m_release = '0;
    m_valid = 1'b0; m_ovf = 1'b0; m_id = '0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic rdy);
    logic all_diff;
    // event slot reacts to the pulses present before this edge
    if (m_press != 4'b0000) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        for (int i = 3; i >= 0; i--) if (m_press[i]) m_id = 2'(i);
        if ($countones(m_press) > 1) m_ovf = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    // input seen by the channels on this edge is the sample two edges back;
    // entries 0..DC are the last DC+1 synchronized values
    samp.push_back(b);
    void'(samp.pop_front());
    m_press = '0; m_release = '0;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j <= DC; j++) if (samp[j][i] == m_level[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) m_press[i] = 1'b1;
        else m_release[i] = 1'b1;
      end
    end
  endtask

  // ---------------- checks ----------------
  task automatic check_model(input string tag);
    vectors++;
    if (btn_level !== m_level || press_pulse !== m_press || release_pulse !== m_release ||
        evt_valid !== m_valid || evt_id !== m_id || evt_overflow !== m_ovf) begin
      miscompares++;
      $display("FAIL %s @%0t: got lvl=%b pr=%b rl=%b v=%b id=%0d ovf=%b, want lvl=%b pr=%b rl=%b v=%b id=%0d ovf=%b",
               tag, $time, btn_level, press_pulse, release_pulse, evt_valid, evt_id, evt_overflow,
               m_level, m_press, m_release, m_valid, m_id, m_ovf);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, want);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(btn_in, evt_ready);
    @(negedge clk);
    check_model(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] btn;
    logic       ready;
    int         cycles;
    logic [3:0] level;
    logic       valid;
    logic [1:0] id;
    logic       ovf;
  } vec_t;

  vec_t tbl[8];
  int   hold;

  initial begin
    //           btn      rdy  cyc  level    v     id     ovf
    tbl[0] = '{4'b0001, 1'b1, 2, 4'b0001, 1'b0, 2'd0, 1'b0}; // consume event
    tbl[1] = '{4'b0101, 1'b1, 3, 4'b0001, 1'b0, 2'd0, 1'b0}; // btn2 glitch starts
    tbl[2] = '{4'b0001, 1'b1, 8, 4'b0001, 1'b0, 2'd0, 1'b0}; // glitch rejected
    tbl[3] = '{4'b1001, 1'b1, 8, 4'b1001, 1'b1, 2'd3, 1'b0}; // press btn3
    tbl[4] = '{4'b1001, 1'b1, 1, 4'b1001, 1'b0, 2'd3, 1'b0}; // consume
    tbl[5] = '{4'b0001, 1'b1, 8, 4'b0001, 1'b0, 2'd3, 1'b0}; // release btn3, no event
    tbl[6] = '{4'b0000, 1'b0, 8, 4'b0000, 1'b0, 2'd3, 1'b0}; // release btn0
    tbl[7] = '{4'b1010, 1'b0, 8, 4'b1010, 1'b1, 2'd1, 1'b1}; // btn1+btn3 together

    // reset
    rst = 1'b0; btn_in = '0; evt_ready = 1'b0;
    model_reset();
    #1;
    check_model("reset_async");
    repeat (2) step("reset_hold");
    check_val("reset.level", 32'(btn_level), 32'h0);
    check_val("reset.valid", 32'(evt_valid), 32'h0);
    rst = 1'b1;

    // exact press latency on btn0
    $display("seq A: press btn0, expect level on edge %0d", 2 + DC);
    btn_in = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step("seqA");
      check_val("A.level0", 32'(btn_level[0]), 32'(k >= 2 + DC));
      check_val("A.press0", 32'(press_pulse[0]), 32'(k == 2 + DC));
      check_val("A.valid", 32'(evt_valid), 32'(k >= 3 + DC));
    end
    check_val("A.id", 32'(evt_id), 32'h0);

    for (int i = 0; i < 8; i++) begin
      btn_in = tbl[i].btn; evt_ready = tbl[i].ready;
      repeat (tbl[i].cycles) step("table");
      $display("row %0d btn=%b rdy=%b -> lvl=%b v=%b id=%0d ovf=%b",
               i, tbl[i].btn, tbl[i].ready, btn_level, evt_valid, evt_id, evt_overflow);
      check_val("row.level", 32'(btn_level), 32'(tbl[i].level));
      check_val("row.valid", 32'(evt_valid), 32'(tbl[i].valid));
      check_val("row.id", 32'(evt_id), 32'(tbl[i].id));
      check_val("row.ovf", 32'(evt_overflow), 32'(tbl[i].ovf));
    end

    // reset in the middle of a WAIT_HI, button kept held
    $display("seq B: reset mid-debounce with btn2 held");
    btn_in = 4'b0100;
    repeat (4) step("seqB.pre");
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_val("B.async.level", 32'(btn_level), 32'h0);
    check_val("B.async.pulses", 32'({press_pulse, release_pulse}), 32'h0);
    check_val("B.async.evt", 32'({evt_valid, evt_id, evt_overflow}), 32'h0);
    repeat (3) step("seqB.rst");
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step("seqB");
      check_val("B.level", 32'(btn_level), (k >= 2 + DC) ? 32'h4 : 32'h0);
      check_val("B.press", 32'(press_pulse), (k == 2 + DC) ? 32'h4 : 32'h0);
      check_val("B.valid", 32'(evt_valid), 32'(k >= 3 + DC));
    end
    check_val("B.id", 32'(evt_id), 32'h2);

    // blocked slot drops a second press
    $display("seq C: press btn0 then btn2 with evt_ready low");
    rst = 1'b0; btn_in = '0; evt_ready = 1'b0;
    repeat (2) step("seqC.rst");
    rst = 1'b1;
    btn_in = 4'b0001;
    repeat (8) step("seqC.p0");
    check_val("C.valid0", 32'(evt_valid), 32'h1);
    check_val("C.ovf0", 32'(evt_overflow), 32'h0);
    btn_in = 4'b0101;
    repeat (8) step("seqC.p2");
    check_val("C.level", 32'(btn_level), 32'h5);
    check_val("C.id", 32'(evt_id), 32'h0);
    check_val("C.ovf", 32'(evt_overflow), 32'h1);
    evt_ready = 1'b1;
    step("seqC.acc");
    check_val("C.cleared", 32'(evt_valid), 32'h0);
    check_val("C.ovf_sticky", 32'(evt_overflow), 32'h1);

    // randomized run against the model
    hold = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 10);
        btn_in = btn_in ^ 4'($urandom_range(0, 15));
      end
      hold--;
      evt_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 799) != 0);
      step("random");
    end
    $display("random phase: 3000 cycles done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of consecutive stable cycles required before a level change is accepted.
REQ-002 SHALL have parameter CNT_W, default 25, the debounce counter width; DEBOUNCE_CYCLES SHALL fit in CNT_W bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low; asserted while 0.
REQ-006 btn_in  input  4  raw asynchronous pushbutton levels; 1 = pressed.
REQ-007 btn_level  output  4  debounced level per button.
REQ-008 press_pulse  output  4  one-cycle pulse per button on each accepted 0->1 transition.
REQ-009 release_pulse  output  4  one-cycle pulse per button on each accepted 1->0 transition.
REQ-010 evt_valid  output  1  press event available.
REQ-011 evt_id  output  2  index of the pressed button; valid while evt_valid=1.
REQ-012 evt_ready  input  1  consumer accepts the event when evt_valid=1 and evt_ready=1.
REQ-013 evt_overflow  output  1  sticky flag: a press event was lost.

Function
REQ-014 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each channel SHALL be an FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-016 STABLE_LO->WAIT_HI SHALL occur when sync=1, with the counter cleared.
REQ-017 In WAIT_HI, sync=0 SHALL return to STABLE_LO with the counter cleared.
REQ-018 In WAIT_HI, the counter SHALL increment on each sync=1 cycle.
REQ-019 WAIT_HI->STABLE_HI SHALL occur on the cycle the counter equals DEBOUNCE_CYCLES-1 with sync=1; btn_level=1 and press_pulse=1 SHALL be registered on that edge.
REQ-020 STABLE_HI, WAIT_LO and release_pulse SHALL behave symmetrically with the polarity inverted.
REQ-021 Latency from the first clock edge sampling a stable new btn_in value to the btn_level change SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no btn_level change and no pulse.
REQ-023 The counter SHALL never wrap; it is bounded by DEBOUNCE_CYCLES-1.
REQ-024 press_pulse and release_pulse SHALL each be high for exactly one cycle per transition.
REQ-025 Event register: on any press_pulse, if evt_valid=0 or (evt_valid=1 and evt_ready=1) that cycle, load evt_id and set evt_valid=1 on the next edge.
REQ-026 When several press_pulse bits are set in one cycle, the lowest index SHALL be loaded, the remaining presses dropped, and evt_overflow set.
REQ-027 A press while evt_valid=1 and evt_ready=0 SHALL be dropped, leave evt_id unchanged, and set evt_overflow.
REQ-028 On acceptance with no new press that cycle, evt_valid SHALL clear on the next edge.
REQ-029 evt_id SHALL hold steady while evt_valid=1 and evt_ready=0.
REQ-030 Release events SHALL NOT enter the event register.

Reset
REQ-031 While rst=0, all of the following SHALL be 0 asynchronously: synchronizers, counters, btn_level, pulses, evt_valid, evt_id, evt_overflow.
REQ-032 While rst=0, all FSMs SHALL be in STABLE_LO.
REQ-033 After release, a button already held SHALL be debounced as a new press.
REQ-034 Reset asserted mid-debounce SHALL discard the partial count.
REQ-035 evt_overflow SHALL clear only by reset.

Structure
REQ-036 A shared package SHALL hold the channel state encoding (2 bits), the button count constant NUM_BTN=4, and the event id width.
REQ-037 One sub-module, debounce_ch (synchronizer + FSM + counter, one button), SHALL be instantiated 4 times; the event logic SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4)
REQ-038 btn_in[0] 0->1 held -> btn_level[0]=1 and press_pulse[0] one cycle, 6 cycles after the first sampling edge; evt_valid=1, evt_id=0 on the next cycle.
REQ-039 btn_in[2] high for 3 cycles, then low -> no level change, no pulse, no event.
REQ-040 btn_in[1] and btn_in[3] rise on the same cycle -> evt_id=1, evt_overflow=1; btn_level=4'b1010.
REQ-041 evt_ready=0, press btn 0, then press btn 2 -> evt_id stays 0, evt_overflow=1; raise evt_ready -> evt_valid clears next cycle.
REQ-042 Release held btn 3 -> release_pulse[3] one cycle after 6 cycles; no event.
REQ-043 rst=0 asserted mid-WAIT_HI -> all outputs 0 immediately; after rst=1 with btn held -> full 6-cycle press latency.
